// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the pipeline MEM
// stage (core port, default priority) and a burst DMA/debug engine.
// The DMA runs auto-incrementing word bursts. A starvation counter forces a
// single DMA beat after DMA_MAX_WAIT consecutive losses to the core.
// Memory reads are combinational and writes are synchronous, so each granted
// beat completes in the cycle it is granted.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   core_req/we/addr/wdata     MEM stage request
//   core_rdata, core_stall     load data, stall when arbitration is lost
//   dma_start/we/base/len      burst launch (sampled on dma_start)
//   dma_wdata, dma_wnext       write-beat data, beat-consumed strobe
//   dma_rvalid, dma_rdata      read-beat strobe and data
//   dma_busy, dma_done         burst in progress, end-of-burst pulse
//   mem_read/write/addr/wdata  data memory controls
//   mem_rdata                  data memory read data
module dmem_arbiter #(
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned DMA_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  input  logic        dma_start,
  input  logic        dma_we,
  input  logic [31:0] dma_base,
  input  logic [4:0]  dma_len,
  input  logic [31:0] dma_wdata,
  output logic        dma_wnext,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        dma_busy,
  output logic        dma_done,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned LEN_W  = 5;
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [LEN_W-1:0]    r_remaining, w_remaining_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt, w_wait_cnt_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                r_we, w_we_nxt;
  logic                r_done, w_done_nxt;

  logic                w_in_burst;
  logic                w_starved;
  logic                w_dma_grant;
  logic                w_core_grant;
  logic [LEN_W-1:0]    w_len_clamped;

  // Arbitration; everything is held off while reset is asserted.
  assign w_in_burst    = (r_state == S_BURST) && !reset;
  assign w_starved     = (r_wait_cnt == WAIT_W'(DMA_MAX_WAIT));
  assign w_dma_grant   = w_in_burst && (!core_req || w_starved);
  assign w_core_grant  = !reset && core_req && !w_dma_grant;
  assign w_len_clamped = (dma_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : dma_len;

  assign core_stall = !reset && core_req && !w_core_grant;
  assign dma_busy   = (r_state == S_BURST);
  assign dma_done   = r_done;

  // State and burst bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_wait_cnt  <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_we        <= w_we_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next-state and burst bookkeeping.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_addr_nxt      = r_addr;
    w_we_nxt        = r_we;
    w_done_nxt      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (dma_start && (dma_len != '0)) begin
          w_state_nxt     = S_BURST;
          w_remaining_nxt = w_len_clamped;
          w_addr_nxt      = dma_base & 32'hFFFF_FFFC;
          w_we_nxt        = dma_we;
          w_wait_cnt_nxt  = '0;
        end
      end
      S_BURST: begin
        if (w_dma_grant) begin
          w_addr_nxt      = r_addr + 32'd4;
          w_remaining_nxt = r_remaining - LEN_W'(1);
          w_wait_cnt_nxt  = '0;
          if (r_remaining == LEN_W'(1)) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end else if (w_core_grant && !w_starved) begin
          // Saturates at DMA_MAX_WAIT; the next pending beat is then forced.
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Memory-side steering for whichever port holds the grant.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    core_rdata = '0;
    dma_rdata  = '0;
    dma_rvalid = 1'b0;
    dma_wnext  = 1'b0;
    if (w_core_grant) begin
      mem_read   = !core_we;
      mem_write  = core_we;
      mem_addr   = core_addr;
      mem_wdata  = core_wdata;
      core_rdata = mem_rdata;
    end else if (w_dma_grant) begin
      mem_addr = r_addr;
      if (r_we) begin
        mem_write = 1'b1;
        mem_wdata = dma_wdata;
        dma_wnext = 1'b1;
      end else begin
        mem_read   = 1'b1;
        dma_rvalid = 1'b1;
        dma_rdata  = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter: core-only access, DMA write burst,
// starvation forcing, clamp/ignore, address wrap and reset mid-burst.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        dma_start;
  logic        dma_we;
  logic [31:0] dma_base;
  logic [4:0]  dma_len;
  logic [31:0] dma_wdata;
  logic        dma_wnext;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        dma_busy;
  logic        dma_done;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks;
  int n_errors;

  dmem_arbiter #(.MAX_BURST(16), .DMA_MAX_WAIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .dma_start  (dma_start),
    .dma_we     (dma_we),
    .dma_base   (dma_base),
    .dma_len    (dma_len),
    .dma_wdata  (dma_wdata),
    .dma_wnext  (dma_wnext),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .dma_busy   (dma_busy),
    .dma_done   (dma_done),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic launch(input logic we, input logic [31:0] base, input logic [4:0] len);
    dma_start = 1'b1;
    dma_we    = we;
    dma_base  = base;
    dma_len   = len;
  endtask

  initial begin
    int beats;
    bit seen;
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    core_req   = 1'b1;
    core_we    = 1'b0;
    core_addr  = 32'h4;
    core_wdata = 32'h0;
    dma_start  = 1'b0;
    dma_we     = 1'b0;
    dma_base   = 32'h0;
    dma_len    = 5'd0;
    dma_wdata  = 32'h0;
    mem_rdata  = 32'hABCD_EF00;

    // Outputs forced to zero while reset is high.
    tick(); tick();
    samp();
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk("rst_core_rdata", core_rdata, 32'h0);
    chk("rst_busy", 32'(dma_busy), 32'd0);
    chk("rst_done", 32'(dma_done), 32'd0);

    // Core-only load, same-cycle data.
    tick();
    reset = 1'b0;
    samp();
    chk("core_stall", 32'(core_stall), 32'd0);
    chk("core_mem_read", 32'(mem_read), 32'd1);
    chk("core_mem_addr", mem_addr, 32'h4);
    chk("core_rdata", core_rdata, 32'hABCD_EF00);

    // DMA write burst with the core idle.
    tick();
    core_req = 1'b0;
    launch(1'b1, 32'h100, 5'd3);
    samp();
    chk("wr_start_idle", 32'(mem_write), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      dma_start = 1'b0;
      dma_wdata = 32'h1000 + 32'(i);
      samp();
      chk("wr_mem_write", 32'(mem_write), 32'd1);
      chk("wr_mem_addr", mem_addr, 32'h100 + 32'(4 * i));
      chk("wr_mem_wdata", mem_wdata, 32'h1000 + 32'(i));
      chk("wr_wnext", 32'(dma_wnext), 32'd1);
      chk("wr_busy", 32'(dma_busy), 32'd1);
      chk("wr_done_early", 32'(dma_done), 32'd0);
    end
    tick();
    samp();
    chk("wr_done", 32'(dma_done), 32'd1);
    chk("wr_busy_fall", 32'(dma_busy), 32'd0);
    chk("wr_idle_write", 32'(mem_write), 32'd0);
    tick();
    samp();
    chk("wr_done_pulse", 32'(dma_done), 32'd0);

    // Starvation: core holds the port, DMA forced on cycles 5 and 10.
    tick();
    core_req  = 1'b1;
    core_addr = 32'h40;
    mem_rdata = 32'h0000_55AA;
    launch(1'b0, 32'h200, 5'd2);
    samp();
    chk("stv_start_stall", 32'(core_stall), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      dma_start = 1'b0;
      samp();
      if (k == 5 || k == 10) begin
        chk("stv_force_stall", 32'(core_stall), 32'd1);
        chk("stv_force_addr", mem_addr, (k == 5) ? 32'h200 : 32'h204);
        chk("stv_rvalid", 32'(dma_rvalid), 32'd1);
        chk("stv_rdata", dma_rdata, 32'h0000_55AA);
      end else begin
        chk("stv_core_stall", 32'(core_stall), 32'd0);
        chk("stv_core_addr", mem_addr, 32'h40);
        chk("stv_no_rvalid", 32'(dma_rvalid), 32'd0);
      end
    end
    tick();
    samp();
    chk("stv_done", 32'(dma_done), 32'd1);
    chk("stv_after_stall", 32'(core_stall), 32'd0);

    // Clamp len=31 to 16 beats; a mid-burst dma_start is ignored.
    tick();
    core_req  = 1'b0;
    launch(1'b0, 32'h300, 5'd31);
    beats = 0;
    seen  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      dma_start = (c == 3);
      dma_base  = 32'h900;
      dma_len   = 5'd5;
      samp();
      if (dma_rvalid) begin
        chk("clamp_addr", mem_addr, 32'h300 + 32'(4 * beats));
        beats++;
      end
      if (dma_done) begin
        seen = 1'b1;
        break;
      end
    end
    dma_start = 1'b0;
    chk("clamp_done_seen", 32'(seen), 32'd1);
    chk("clamp_beats", 32'(beats), 32'd16);
    tick();
    samp();
    chk("clamp_busy_after", 32'(dma_busy), 32'd0);

    // len=0 is ignored entirely.
    tick();
    launch(1'b1, 32'h700, 5'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      dma_start = 1'b0;
      samp();
      chk("len0_busy", 32'(dma_busy), 32'd0);
      chk("len0_done", 32'(dma_done), 32'd0);
      chk("len0_write", 32'(mem_write), 32'd0);
    end

    // Address wrap, then restart in the same cycle as dma_done.
    tick();
    launch(1'b1, 32'hFFFF_FFFC, 5'd2);
    tick();
    dma_start = 1'b0;
    samp();
    chk("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
    tick();
    samp();
    chk("wrap_addr1", mem_addr, 32'h0000_0000);
    tick();
    launch(1'b1, 32'h600, 5'd1);
    samp();
    chk("wrap_done", 32'(dma_done), 32'd1);
    tick();
    dma_start = 1'b0;
    samp();
    chk("restart_addr", mem_addr, 32'h600);
    chk("restart_write", 32'(mem_write), 32'd1);
    tick();
    samp();
    chk("restart_done", 32'(dma_done), 32'd1);

    // Reset after 2 of 5 beats abandons the burst silently.
    tick();
    launch(1'b1, 32'h400, 5'd5);
    for (int i = 0; i < 2; i++) begin
      tick();
      dma_start = 1'b0;
      samp();
      chk("rmb_beat_addr", mem_addr, 32'h400 + 32'(4 * i));
    end
    tick();
    reset = 1'b1;
    samp();
    chk("rmb_in_reset_write", 32'(mem_write), 32'd0);
    tick();
    reset = 1'b0;
    samp();
    chk("rmb_busy", 32'(dma_busy), 32'd0);
    chk("rmb_write", 32'(mem_write), 32'd0);
    chk("rmb_no_done", 32'(dma_done), 32'd0);
    tick();
    launch(1'b1, 32'h500, 5'd1);
    samp();
    chk("rmb_no_done2", 32'(dma_done), 32'd0);
    tick();
    dma_start = 1'b0;
    samp();
    chk("rmb_new_addr", mem_addr, 32'h500);
    chk("rmb_new_write", 32'(mem_write), 32'd1);
    tick();
    samp();
    chk("rmb_new_done", 32'(dma_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
